reg_bank_relay: RTL and testbench

- Parametrised general-purpose register bank for the relay computer register unit; generalises the single ALU-operand register to NUM_REGS registers of WIDTH bits.
- Each register has a one-hot load strobe from the control bus and a one-hot select strobe.
- Emulates relay pickup time with per-path settle counters.
- Continuously feeds the ALU B and C operands and mirrors strobes to the LED panel.

---
 rtl/reg_bank_relay_pkg.sv | 55 +++++
 rtl/reg_bank_relay_if.sv | 40 ++++
 rtl/reg_bank_relay_settle.sv | 140 ++++++++++++++
 rtl/reg_bank_relay.sv | 108 ++++++++++
 tb/tb_reg_bank_relay.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_bank_relay_pkg.sv
// reg_bank_pkg: shared types and helpers for the relay computer register bank.
//
// Contents:
//   settle_state_e          - strobe FSM states. HOLD is the terminal state of
//                             both paths: it means "written, wait for release"
//                             on the load path and DRIVE on the select path.
//   popcount / onehot_valid / onehot_multi / onehot_idx
//                           - strobe decode helpers. They take a MAX_REGS-wide
//                             vector, so callers zero-extend narrower strobes.
//   IDX_A..IDX_D            - default register indices (A,B,C,D).
package reg_bank_pkg;

    localparam int MAX_REGS = 32;

    localparam int IDX_A = 0;
    localparam int IDX_B = 1;
    localparam int IDX_C = 2;
    localparam int IDX_D = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } settle_state_e;

    function automatic int unsigned popcount(input logic [MAX_REGS-1:0] vec);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < MAX_REGS; i++) begin
            cnt += 32'(vec[i]);
        end
        return cnt;
    endfunction

    function automatic logic onehot_valid(input logic [MAX_REGS-1:0] vec);
        return popcount(vec) == 1;
    endfunction

    function automatic logic onehot_multi(input logic [MAX_REGS-1:0] vec);
        return popcount(vec) > 1;
    endfunction

    // Index of the set bit; only meaningful when onehot_valid(vec) is true.
    function automatic int unsigned onehot_idx(input logic [MAX_REGS-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_REGS; i++) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/reg_bank_relay_if.sv
// reg_bank_relay_if: control-bus / data-bus / ALU / panel bundle of the
// register bank.
//
// Signals:
//   ld, sel      one-hot load / select strobes from the control bus
//   data_in      data bus value to load
//   data_out     selected register value (0 when data_oe=0)
//   data_oe      bank is driving the data bus
//   alu_b/alu_c  live ALU operand registers
//   led_ld/led_sel registered copies of the raw strobes for the LED panel
//   ld_busy      load settle in progress
//   err          registered flag for a multi-hot ld or sel
// Modports: master = control unit / bench side, slave = register bank.
interface reg_bank_relay_if #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4
);
    logic [NUM_REGS-1:0] ld;
    logic [NUM_REGS-1:0] sel;
    logic [WIDTH-1:0]    data_in;
    logic [WIDTH-1:0]    data_out;
    logic                data_oe;
    logic [WIDTH-1:0]    alu_b;
    logic [WIDTH-1:0]    alu_c;
    logic [NUM_REGS-1:0] led_ld;
    logic [NUM_REGS-1:0] led_sel;
    logic                ld_busy;
    logic                err;

    modport master (
        output ld, sel, data_in,
        input  data_out, data_oe, alu_b, alu_c, led_ld, led_sel, ld_busy, err
    );

    modport slave (
        input  ld, sel, data_in,
        output data_out, data_oe, alu_b, alu_c, led_ld, led_sel, ld_busy, err
    );

endinterface

// File: rtl/reg_bank_relay_settle.sv
// relay_settle: strobe-stability FSM emulating relay pickup time.
//
// A one-hot strobe must stay unchanged for max(SETTLE_CYCLES,1) cycles,
// counting the cycle it is first seen, before fire_o pulses (the edge at the
// end of that cycle is the "pickup" edge). The FSM then sits in HOLD until
// the strobe changes or drops. A zero or multi-hot strobe aborts settling.
//
// Build option: RELAY_SETTLE_EN. When undefined the counter is compiled out
// and every legal strobe fires on the first edge it is seen (SETTLE_CYCLES=0).
//
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   strb_i        raw strobe vector
//   fire_o        combinational: the latched target picks up on this edge
//   active_o      in HOLD (written / driving)
//   busy_o        in SETTLE
//   idx_o         target index (valid with fire_o and while active_o)
//   illegal_o     combinational: strobe is multi-hot this cycle
module relay_settle
    import reg_bank_pkg::*;
#(
    parameter int N             = 4,
    parameter int SETTLE_CYCLES = 3,
    parameter int IDX_W         = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     strb_i,
    output logic             fire_o,
    output logic             active_o,
    output logic             busy_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             illegal_o
);

`ifdef RELAY_SETTLE_EN
    localparam bit SETTLE_ON = (SETTLE_CYCLES > 1);
    localparam int CNT_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    // SETTLE_CYCLES is kept so both builds instantiate identically.
    localparam bit SETTLE_ON = 1'b0 && (SETTLE_CYCLES > 1);
`endif

    settle_state_e       state_q, state_d;
    logic [N-1:0]        strb_q, strb_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [MAX_REGS-1:0] strb_ext;
    logic                legal;
    logic                fire;

    assign strb_ext  = MAX_REGS'(strb_i);
    assign legal     = onehot_valid(strb_ext);
    assign illegal_o = onehot_multi(strb_ext);

    always_comb begin
        state_d = state_q;
        strb_d  = strb_q;
        idx_d   = idx_q;
        fire    = 1'b0;
`ifdef RELAY_SETTLE_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (legal) begin
                    strb_d = strb_i;
                    idx_d  = IDX_W'(onehot_idx(strb_ext));
                    if (SETTLE_ON) begin
                        state_d = SETTLE;
`ifdef RELAY_SETTLE_EN
                        // The detection cycle already counts as one stable cycle.
                        cnt_d   = CNT_W'(1);
`endif
                    end else begin
                        fire    = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            SETTLE: begin
`ifdef RELAY_SETTLE_EN
                if (strb_i == strb_q) begin
                    if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        fire    = 1'b1;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (legal) begin
                    // Different target: restart settling from its first cycle.
                    strb_d = strb_i;
                    idx_d  = IDX_W'(onehot_idx(strb_ext));
                    cnt_d  = CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            HOLD: begin
                if (strb_i != strb_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            strb_q  <= '0;
            idx_q   <= '0;
`ifdef RELAY_SETTLE_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            strb_q  <= strb_d;
            idx_q   <= idx_d;
`ifdef RELAY_SETTLE_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // idx_d equals idx_q except on the IDLE fire edge, so it serves both the
    // write port (with fire_o) and the read mux (while active_o).
    assign fire_o   = fire;
    assign idx_o    = idx_d;
    assign active_o = (state_q == HOLD);
`ifdef RELAY_SETTLE_EN
    assign busy_o   = (state_q == SETTLE);
`else
    assign busy_o   = 1'b0;
`endif

endmodule

// File: rtl/reg_bank_relay.sv
// reg_bank_relay: NUM_REGS x WIDTH general-purpose register bank of the relay
// computer register unit.
//
// Each register is loaded by a one-hot ld strobe and read onto the data bus
// by a one-hot sel strobe; both strobes pass through a relay_settle FSM that
// emulates relay pickup time. Registers ALU_B_IDX / ALU_C_IDX feed the ALU
// continuously, and the raw strobes are mirrored to the LED panel.
//
// Build option: RELAY_SETTLE_EN (see relay_settle). Undefined = no settle
// delay, ld_busy tied low.
//
// Ports:
//   clock   system clock, all state on rising edge
//   reset   synchronous, active-high; clears registers, FSMs and outputs
//   bus     reg_bank_relay_if.slave: ld, sel, data_in in; data_out, data_oe,
//           alu_b, alu_c, led_ld, led_sel, ld_busy, err out
module reg_bank_relay
    import reg_bank_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int NUM_REGS      = 4,
    parameter int SETTLE_CYCLES = 3,
    parameter int ALU_B_IDX     = IDX_B,
    parameter int ALU_C_IDX     = IDX_C
) (
    input  logic              clock,
    input  logic              reset,
    reg_bank_relay_if.slave   bus
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [WIDTH-1:0]    regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] led_ld_q;
    logic [NUM_REGS-1:0] led_sel_q;
    logic                err_q;

    logic             ld_fire, ld_active, ld_busy, ld_illegal;
    logic [IDX_W-1:0] ld_idx;
    logic             sel_fire, sel_active, sel_busy, sel_illegal;
    logic [IDX_W-1:0] sel_idx;

    relay_settle #(
        .N             (NUM_REGS),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .IDX_W         (IDX_W)
    ) u_ld_settle (
        .clk_i     (clock),
        .rst_i     (reset),
        .strb_i    (bus.ld),
        .fire_o    (ld_fire),
        .active_o  (ld_active),
        .busy_o    (ld_busy),
        .idx_o     (ld_idx),
        .illegal_o (ld_illegal)
    );

    relay_settle #(
        .N             (NUM_REGS),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .IDX_W         (IDX_W)
    ) u_sel_settle (
        .clk_i     (clock),
        .rst_i     (reset),
        .strb_i    (bus.sel),
        .fire_o    (sel_fire),
        .active_o  (sel_active),
        .busy_o    (sel_busy),
        .idx_o     (sel_idx),
        .illegal_o (sel_illegal)
    );

    // Path flags that this bank has no use for.
    logic unused_path_flags;
    assign unused_path_flags = ld_active ^ sel_fire ^ sel_busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            led_ld_q  <= '0;
            led_sel_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (ld_fire) begin
                regs_q[ld_idx] <= bus.data_in;
            end
            led_ld_q  <= bus.ld;
            led_sel_q <= bus.sel;
            // One flag for both paths, so simultaneous illegal ld and sel
            // still give a single pulse.
            err_q     <= ld_illegal | sel_illegal;
        end
    end

    // Read side is combinational from the registers, so a same-cycle load
    // shows up on data_out from the cycle after its write edge.
    assign bus.data_oe  = sel_active;
    assign bus.data_out = sel_active ? regs_q[sel_idx] : '0;
    assign bus.alu_b    = regs_q[ALU_B_IDX];
    assign bus.alu_c    = regs_q[ALU_C_IDX];
    assign bus.led_ld   = led_ld_q;
    assign bus.led_sel  = led_sel_q;
    assign bus.ld_busy  = ld_busy;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_reg_bank_relay.sv
// Bench for reg_bank_relay: directed sequences followed by random strobes,
// checked every cycle against a strobe-history reference model.
module tb_reg_bank_relay;

    localparam int W  = 8;
    localparam int NR = 4;
    localparam int SC = 3;
`ifdef RELAY_SETTLE_EN
    localparam int EFF_SC = SC;
`else
    localparam int EFF_SC = 0;
`endif
    // Number of consecutive stable cycles a strobe needs before it acts.
    localparam int NEED = (EFF_SC > 1) ? EFF_SC : 1;

    logic clk = 1'b0;
    logic rst;

    reg_bank_relay_if #(.WIDTH(W), .NUM_REGS(NR)) bus ();

    reg_bank_relay #(
        .WIDTH         (W),
        .NUM_REGS      (NR),
        .SETTLE_CYCLES (SC),
        .ALU_B_IDX     (1),
        .ALU_C_IDX     (2)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [W-1:0]  mregs [NR];
    int            run_l, run_s;     // consecutive cycles the current strobe was stable
    logic [NR-1:0] tgt_l, tgt_s;     // strobe being settled / held
    bit            done_l, done_s;   // strobe completed (written / driving)
    logic [NR-1:0] m_led_ld, m_led_sel;
    bit            m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int oh_idx(input logic [NR-1:0] v);
        int k;
        k = 0;
        for (int i = 0; i < NR; i++) if (v[i]) k = i;
        return k;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        run_l = 0; run_s = 0; tgt_l = '0; tgt_s = '0;
        done_l = 0; done_s = 0;
        m_led_ld = '0; m_led_sel = '0; m_err = 0;
    endtask

    // One edge of strobe history: a strobe acts once it has been the same
    // one-hot value for NEED cycles; after acting it is ignored until it changes.
    task automatic path_update(input logic [NR-1:0] v, inout int run,
                               inout logic [NR-1:0] tgt, inout bit done, output bit fire);
        fire = 0;
        if (done) begin
            if (v != tgt) begin
                done = 0;
                run  = 0;
            end
        end else if ($countones(v) != 1) begin
            run = 0;
        end else begin
            if (run > 0 && v == tgt) run++;
            else begin
                run = 1;
                tgt = v;
            end
            if (run >= NEED) begin
                fire = 1;
                done = 1;
            end
        end
    endtask

    task automatic check_outputs();
        check("alu_b", 32'(bus.alu_b), 32'(mregs[1]));
        check("alu_c", 32'(bus.alu_c), 32'(mregs[2]));
        check("data_oe", 32'(bus.data_oe), 32'(done_s));
        check("data_out", 32'(bus.data_out), done_s ? 32'(mregs[oh_idx(tgt_s)]) : 32'd0);
        check("ld_busy", 32'(bus.ld_busy), 32'(!done_l && run_l > 0));
        check("led_ld", 32'(bus.led_ld), 32'(m_led_ld));
        check("led_sel", 32'(bus.led_sel), 32'(m_led_sel));
        check("err", 32'(bus.err), 32'(m_err));
    endtask

    task automatic step(input logic [NR-1:0] l, input logic [NR-1:0] s,
                        input logic [W-1:0] d, input bit r);
        bit fire_l;
        bit unused_fire_s;
        bus.ld = l;
        bus.sel = s;
        bus.data_in = d;
        rst = r;
        @(posedge clk);
        if (r) begin
            model_clear();
        end else begin
            path_update(l, run_l, tgt_l, done_l, fire_l);
            path_update(s, run_s, tgt_s, done_s, unused_fire_s);
            if (fire_l) mregs[oh_idx(tgt_l)] = d;
            m_led_ld  = l;
            m_led_sel = s;
            m_err     = ($countones(l) > 1) || ($countones(s) > 1);
        end
        #1;
        check_outputs();
    endtask

    function automatic logic [NR-1:0] next_strobe(input logic [NR-1:0] prev);
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 5) return prev;
        else if (r < 7) return '0;
        else if (r < 9) return NR'(1) << $urandom_range(0, NR - 1);
        else return NR'($urandom);
    endfunction

    initial begin
        logic [NR-1:0] l, s;
        logic [W-1:0]  d;

        rst = 1'b1;
        bus.ld = '0;
        bus.sel = '0;
        bus.data_in = '0;
        model_clear();

        // Reset state
        step('0, '0, 8'h00, 1);
        step('0, '0, 8'h00, 1);
        step('0, '0, 8'h00, 0);

        // Load C with A5, strobe held 3 cycles
        repeat (3) step(4'b0100, '0, 8'hA5, 0);
        check("load_c", 32'(bus.alu_c), 32'hA5);
        step('0, '0, 8'h00, 0);

        // Load B strobe dropped after 2 cycles
        repeat (2) step(4'b0010, '0, 8'h3C, 0);
        step('0, '0, 8'h3C, 0);
`ifdef RELAY_SETTLE_EN
        check("abort_b", 32'(bus.alu_b), 32'h00);
`else
        check("abort_b", 32'(bus.alu_b), 32'h3C);
`endif
        check("abort_busy", 32'(bus.ld_busy), 32'd0);

        // Held strobe writes once; later data ignored
        repeat (5) step(4'b0010, '0, 8'h11, 0);
        repeat (5) step(4'b0010, '0, 8'h22, 0);
        check("hold_b", 32'(bus.alu_b), 32'h11);
        step('0, '0, 8'h00, 0);

        // Load A then select it
        repeat (3) step(4'b0001, '0, 8'h7E, 0);
        step('0, '0, 8'h00, 0);
        repeat (3) step('0, 4'b0001, 8'h00, 0);
        check("sel_a_oe", 32'(bus.data_oe), 32'd1);
        check("sel_a_out", 32'(bus.data_out), 32'h7E);
        step('0, '0, 8'h00, 0);
        check("sel_drop_oe", 32'(bus.data_oe), 32'd0);
        check("sel_drop_out", 32'(bus.data_out), 32'd0);

        // Multi-hot strobes
        step(4'b0110, '0, 8'hFF, 0);
        check("err_ld", 32'(bus.err), 32'd1);
        step('0, '0, 8'h00, 0);
        check("err_clear", 32'(bus.err), 32'd0);
        step(4'b0110, 4'b0011, 8'hFF, 0);
        check("err_both", 32'(bus.err), 32'd1);
        step('0, '0, 8'h00, 0);
        check("err_both_clr", 32'(bus.err), 32'd0);

        // Same register loaded while selected
        repeat (3) step('0, 4'b0100, 8'h00, 0);
        repeat (4) step(4'b0100, 4'b0100, 8'h5A, 0);
        check("same_reg", 32'(bus.data_out), 32'h5A);
        step('0, '0, 8'h00, 0);

        // Reset in the middle of a load
        step(4'b1000, '0, 8'h55, 0);
        step(4'b1000, '0, 8'h55, 1);
        check("rst_alu_c", 32'(bus.alu_c), 32'd0);
        check("rst_busy", 32'(bus.ld_busy), 32'd0);
        step('0, '0, 8'h00, 0);

        // Random strobes
        l = '0;
        s = '0;
        for (int i = 0; i < 800; i++) begin
            l = next_strobe(l);
            s = next_strobe(s);
            d = W'($urandom);
            step(l, s, d, $urandom_range(0, 99) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
